// File: rtl/hilo_mult_ctrl.sv
// HI/LO register pair with an iterative radix-2 shift-add unsigned multiplier.
// Raises a combinational stall while a multiply is running and the pipeline touches HI/LO.
module hilo_mult_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] mcand, mplier;
  logic [2*WIDTH:0] acc, acc_nx;
  logic [WIDTH:0]   sum;
  logic [CW-1:0]    cnt;
  logic             last;

  // Extra top bit keeps the carry of the partial-product add before the shift.
  always_comb begin
    sum    = acc[2*WIDTH:WIDTH] + (mplier[0] ? {1'b0, mcand} : '0);
    acc_nx = {1'b0, sum, acc[WIDTH-1:0]} >> 1;
    last   = (cnt == CW'(WIDTH-1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (!flush && start) state_nx = RUN;
      RUN:  if (flush || last)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign stall = busy & (start | rd_hi | rd_lo | mthi | mtlo);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == RUN);
      done  <= 1'b0;
      case (state)
        IDLE: if (!flush) begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: if (!flush) begin
          acc    <= acc_nx;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            {hi, lo} <= acc_nx[2*WIDTH-1:0];
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
